// File: rtl/dekatron_driver.sv
// Dekatron step driver: three P1/P2 pulses per digit step, digit/carry/borrow tracking.
// Define DEKATRON_READBACK_EN to decode the glow position from the cathode pins.
module dekatron_driver #(
  parameter int PULSE_GAP = 1,
  parameter int CATHODES  = 30
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  input  logic                cmd_dir,
  output logic                cmd_ready,
  output logic                P1,
  output logic                P2,
  input  logic [CATHODES-1:0] cathodes,
  output logic [3:0]          digit,
  output logic                digit_valid,
  output logic                carry,
  output logic                borrow,
  output logic                fault
);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP,
    CHECK
  } state_e;

  localparam logic [3:0] GAP_END = 4'(PULSE_GAP - 1);

  state_e     state_q, state_d;
  logic [1:0] npulse_q, npulse_d;
  logic [3:0] gap_q, gap_d;
  logic       dir_q, dir_d;
  logic [3:0] digit_q, digit_d;
  logic       valid_q, valid_d;
  logic       carry_q, carry_d;
  logic       borrow_q, borrow_d;
  logic       fault_q, fault_d;

  logic       accept;
  logic [3:0] exp_digit;
  logic       wrap_fwd;
  logic       wrap_bwd;

  assign cmd_ready   = (state_q == IDLE) & ~fault_q;
  assign accept      = cmd_valid & cmd_ready;
  assign P1          = (state_q == PULSE) & ~dir_q & ~fault_q;
  assign P2          = (state_q == PULSE) & dir_q & ~fault_q;
  assign digit       = digit_q;
  assign digit_valid = valid_q;
  assign carry       = carry_q;
  assign borrow      = borrow_q;
  assign fault       = fault_q;

  assign wrap_fwd  = ~dir_q & (digit_q == 4'd9);
  assign wrap_bwd  = dir_q & (digit_q == 4'd0);
  assign exp_digit = dir_q
    ? (wrap_bwd ? 4'd9 : digit_q - 4'd1)
    : (wrap_fwd ? 4'd0 : digit_q + 4'd1);

`ifdef DEKATRON_READBACK_EN
  logic [1:0] rb_hits;
  logic [3:0] rb_dig;
  logic       rb_main;
  logic       rb_ok;

  // Decode glow position: hit count (saturating), digit and main/guide flag.
  always_comb begin
    rb_hits = 2'd0;
    rb_dig  = 4'd0;
    rb_main = 1'b0;
    for (int i = 0; i < CATHODES; i++) begin
      if (cathodes[i]) begin
        if (rb_hits != 2'd2) rb_hits = rb_hits + 2'd1;
        rb_dig  = 4'(i / 3);
        rb_main = (i % 3) == 0;
      end
    end
  end

  assign rb_ok = (rb_hits == 2'd1) & rb_main;
`else
  logic unused_cathodes;
  assign unused_cathodes = ^cathodes;
`endif

  // Sequencer next state: pulse, gap, repeat three times, then verify.
  always_comb begin
    state_d  = state_q;
    npulse_d = npulse_q;
    gap_d    = gap_q;
    dir_d    = dir_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = PULSE;
          dir_d    = cmd_dir;
          npulse_d = 2'd0;
        end
      end
      PULSE: begin
        state_d  = GAP;
        gap_d    = 4'd0;
        npulse_d = npulse_q + 2'd1;
      end
      GAP: begin
        if (gap_q == GAP_END) begin
          state_d = (npulse_q == 2'd3) ? CHECK : PULSE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      CHECK: begin
        state_d  = IDLE;
        npulse_d = 2'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Digit tracking, carry/borrow strobes and readback fault.
  always_comb begin
    digit_d  = digit_q;
    valid_d  = valid_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    fault_d  = fault_q;
`ifdef DEKATRON_READBACK_EN
    if (state_q == IDLE) begin
      valid_d = rb_ok;
      if (rb_ok) digit_d = rb_dig;
    end
    if (state_q == CHECK) begin
      if (!rb_ok || (rb_dig != exp_digit)) begin
        fault_d = 1'b1;
      end else begin
        digit_d  = exp_digit;
        carry_d  = wrap_fwd;
        borrow_d = wrap_bwd;
      end
    end
`else
    valid_d = 1'b1;
    fault_d = 1'b0;
    if (state_q == CHECK) begin
      digit_d  = exp_digit;
      carry_d  = wrap_fwd;
      borrow_d = wrap_bwd;
    end
`endif
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      npulse_q <= 2'd0;
      gap_q    <= 4'd0;
      dir_q    <= 1'b0;
      digit_q  <= 4'd0;
      valid_q  <= 1'b0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      npulse_q <= npulse_d;
      gap_q    <= gap_d;
      dir_q    <= dir_d;
      digit_q  <= digit_d;
      valid_q  <= valid_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      fault_q  <= fault_d;
    end
  end

endmodule

// File: doc/dekatron_driver.md
DEKATRON_DRIVER -- requirements
Module: dekatron_driver

Interface
REQ-001 Parameter: PULSE_GAP, 1, idle cycles after each P1/P2 pulse (legal range 1..15).
REQ-002 Parameter: CATHODES, 30, cathode count of the driven tube; 3 cathodes per digit (main + 2 guides).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  step request.
REQ-006 cmd_dir  input  1  0 = +1 digit (P1 pulses), 1 = -1 digit (P2 pulses).
REQ-007 cmd_ready  output  1  driver can accept a command.
REQ-008 P1  output  1  forward step pulse to the tube.
REQ-009 P2  output  1  backward step pulse to the tube.
REQ-010 cathodes  input  CATHODES  one-hot glow position from the tube; bit 0 = digit 0 main cathode.
REQ-011 digit  output  4  current digit, 0..9.
REQ-012 digit_valid  output  1  digit is trustworthy.
REQ-013 carry  output  1  1-cycle pulse on a 9->0 forward step.
REQ-014 borrow  output  1  1-cycle pulse on a 0->9 backward step.
REQ-015 fault  output  1  sticky readback error.

Function
REQ-016 FSM states SHALL be IDLE, PULSE, GAP, CHECK.
REQ-017 cmd_ready SHALL be 1 only in IDLE with fault=0; accept = cmd_valid & cmd_ready at a rising edge; cmd_dir sampled only then.
REQ-018 Accept SHALL go to PULSE; PULSE lasts exactly 1 cycle, drives P1 (dir 0) or P2 (dir 1) high; P1 and P2 SHALL never be high together.
REQ-019 GAP SHALL last PULSE_GAP cycles with P1=P2=0, then go to PULSE if fewer than 3 pulses issued, else CHECK.
REQ-020 CHECK SHALL last 1 cycle, then IDLE; latency accept -> cmd_ready high = 3*(1+PULSE_GAP)+1 cycles (7 at default).
REQ-021 Expected digit SHALL be (digit+1) mod 10 for dir 0, (digit+9) mod 10 for dir 1.
REQ-022 carry SHALL pulse in the first IDLE cycle after CHECK of a forward step from 9; borrow likewise for a backward step from 0; both 0 otherwise.
REQ-023 cmd_valid held high SHALL produce back-to-back commands with one IDLE cycle between them.
REQ-024 cmd_valid while not ready SHALL be ignored, not queued.
REQ-025 Once fault=1, cmd_ready SHALL stay 0 and P1/P2 stay 0 until reset.

Reset
REQ-026 reset_n low SHALL immediately force IDLE, P1=P2=0, digit=0, digit_valid=0, carry=borrow=0, fault=0, pulse count=0.
REQ-027 Reset asserted mid-sequence SHALL abort it with no further pulses; the first cycle after release is IDLE.

Configuration
REQ-028 Macro DEKATRON_READBACK_EN SHALL select cathode readback.
REQ-029 With DEKATRON_READBACK_EN: each IDLE cycle, digit <= index/3 and digit_valid <= 1 if cathodes is one-hot with index mod 3 = 0, else digit_valid <= 0 (digit held).
REQ-030 With DEKATRON_READBACK_EN: in CHECK, non-one-hot cathodes, a guide index, or a decoded digit not equal to the expected digit SHALL set fault.
REQ-031 With DEKATRON_READBACK_EN: on a passing CHECK, digit SHALL take the expected digit.
REQ-032 Without DEKATRON_READBACK_EN: cathodes SHALL be ignored and fault tied 0.
REQ-033 Without DEKATRON_READBACK_EN: digit SHALL be an internal mod-10 counter updated in CHECK, and digit_valid SHALL be 1 from the first cycle after reset release.

Verification
REQ-034 Reset release with cathodes=bit0 -> digit=0, digit_valid=1 by second cycle, cmd_ready=1.
REQ-035 Ten forward commands against the tube model -> P1 pulses 30 total, digit 1..9 then 0, carry exactly once on the 10th, fault=0.
REQ-036 One backward command at digit 0 -> three P2 pulses 2 cycles apart, digit=9, borrow one cycle, cmd_ready back after 7 cycles.
REQ-037 Readback build, cathodes forced to bit 4 during CHECK -> fault=1, cmd_ready=0, no further pulses.
REQ-038 reset_n low after the 2nd pulse of a command -> P1=P2=0 immediately, state IDLE, digit=0 after release.
REQ-039 cmd_valid held high with PULSE_GAP=3 -> pulses 4 cycles apart, 13 cycles per command, 1 IDLE cycle between commands.
